// File: rtl/arith_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : arith_op_sequencer
// Description : AXI4-Lite master that writes operand A, operand B and opcode
//               to the arithmetic_operations slave, reads back the result and
//               returns it with a sticky error flag. Optional build macro
//               ARITH_SEQ_SKIP_UNCHANGED_EN skips operand writes whose value
//               the slave already holds.
// Revision    : 1.0 - initial release
// ============================================================================
module arith_op_sequencer #(
    parameter int                            C_M_AXI_ADDR_WIDTH = 32,
    parameter int                            C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0
) (
    input  logic                          ACLK,
    input  logic                          ARESETN,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_op_a,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_op_b,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] cmd_opcode,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0] rsp_result,
    output logic                          rsp_error,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                          M_AXI_AWVALID,
    input  logic                          M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic                          M_AXI_WVALID,
    input  logic                          M_AXI_WREADY,
    input  logic [1:0]                    M_AXI_BRESP,
    input  logic                          M_AXI_BVALID,
    output logic                          M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam int AW = C_M_AXI_ADDR_WIDTH;
    localparam int DW = C_M_AXI_DATA_WIDTH;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WR_A   = 3'd1;
    localparam logic [2:0] S_WR_B   = 3'd2;
    localparam logic [2:0] S_WR_OP  = 3'd3;
    localparam logic [2:0] S_RD_RES = 3'd4;
    localparam logic [2:0] S_RSP    = 3'd5;

    localparam logic [1:0]    C_RESP_OKAY = 2'b00;
    localparam logic [AW-1:0] C_OFF_A     = AW'(32'h0);
    localparam logic [AW-1:0] C_OFF_B     = AW'(32'h4);
    localparam logic [AW-1:0] C_OFF_OP    = AW'(32'h8);
    localparam logic [AW-1:0] C_OFF_RES   = AW'(32'hC);

    logic [2:0]    r_state, w_state_nxt;
    logic          r_cmd_ready, w_cmd_ready_nxt;
    logic          r_awvalid, w_awvalid_nxt;
    logic          r_wvalid, w_wvalid_nxt;
    logic          r_bready, w_bready_nxt;
    logic          r_arvalid, w_arvalid_nxt;
    logic          r_rready, w_rready_nxt;
    logic [AW-1:0] r_awaddr, w_awaddr_nxt;
    logic [AW-1:0] r_araddr, w_araddr_nxt;
    logic [DW-1:0] r_wdata, w_wdata_nxt;
    logic          r_rsp_valid, w_rsp_valid_nxt;
    logic [DW-1:0] r_rsp_result, w_rsp_result_nxt;
    logic          r_rsp_error, w_rsp_error_nxt;
    logic [DW-1:0] r_op_a, w_op_a_nxt;
    logic [DW-1:0] r_op_b, w_op_b_nxt;
    logic [DW-1:0] r_opcode, w_opcode_nxt;
    logic          r_err, w_err_nxt;
    logic          r_aw_done, w_aw_done_nxt;
    logic          r_w_done, w_w_done_nxt;
    logic          r_b_done, w_b_done_nxt;

    logic          w_cmd_hs, w_rsp_hs;
    logic          w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic          w_wr_state, w_wr_done, w_resp_err;
    logic [DW-1:0] w_src_a, w_src_b, w_src_op;
    logic          w_skip_a, w_skip_b;

    assign w_cmd_hs = cmd_valid & r_cmd_ready;
    assign w_rsp_hs = r_rsp_valid & rsp_ready;
    assign w_aw_hs  = r_awvalid & M_AXI_AWREADY;
    assign w_w_hs   = r_wvalid & M_AXI_WREADY;
    assign w_b_hs   = r_bready & M_AXI_BVALID;
    assign w_ar_hs  = r_arvalid & M_AXI_ARREADY;
    assign w_r_hs   = r_rready & M_AXI_RVALID;

    assign w_wr_state = (r_state == S_WR_A) | (r_state == S_WR_B) | (r_state == S_WR_OP);
    // B may precede or coincide with the last AW/W handshake, so each leg is tracked separately
    assign w_wr_done  = w_wr_state & (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)
                      & (r_b_done | w_b_hs);
    assign w_resp_err = (w_b_hs & (M_AXI_BRESP != C_RESP_OKAY))
                      | (w_r_hs & (M_AXI_RRESP != C_RESP_OKAY));

    assign w_src_a  = w_cmd_hs ? cmd_op_a   : r_op_a;
    assign w_src_b  = w_cmd_hs ? cmd_op_b   : r_op_b;
    assign w_src_op = w_cmd_hs ? cmd_opcode : r_opcode;

`ifdef ARITH_SEQ_SKIP_UNCHANGED_EN
    logic [DW-1:0] r_cache_a, r_cache_b;
    logic          r_cache_vld;

    assign w_skip_a = r_cache_vld & (w_src_a == r_cache_a);
    assign w_skip_b = r_cache_vld & (w_src_b == r_cache_b);

    // Cache is only trusted once both operands reached the slave without any error
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_cache_a   <= '0;
            r_cache_b   <= '0;
            r_cache_vld <= 1'b0;
        end else begin
            if (w_b_hs && (M_AXI_BRESP == C_RESP_OKAY) && (r_state == S_WR_A)) begin
                r_cache_a <= r_op_a;
            end
            if (w_b_hs && (M_AXI_BRESP == C_RESP_OKAY) && (r_state == S_WR_B)) begin
                r_cache_b   <= r_op_b;
                r_cache_vld <= ~r_err;
            end
            if (w_resp_err) begin
                r_cache_vld <= 1'b0;
            end
        end
    end
`else
    assign w_skip_a = 1'b0;
    assign w_skip_b = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_hs) begin
                    w_state_nxt = !w_skip_a ? S_WR_A : (!w_skip_b ? S_WR_B : S_WR_OP);
                end
            end
            S_WR_A:   if (w_wr_done) w_state_nxt = !w_skip_b ? S_WR_B : S_WR_OP;
            S_WR_B:   if (w_wr_done) w_state_nxt = S_WR_OP;
            S_WR_OP:  if (w_wr_done) w_state_nxt = S_RD_RES;
            S_RD_RES: if (w_r_hs)    w_state_nxt = S_RSP;
            S_RSP:    if (w_rsp_hs)  w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_cmd_ready_nxt  = r_cmd_ready;
        w_awvalid_nxt    = r_awvalid & ~w_aw_hs;
        w_wvalid_nxt     = r_wvalid & ~w_w_hs;
        w_bready_nxt     = r_bready;
        w_arvalid_nxt    = r_arvalid & ~w_ar_hs;
        w_rready_nxt     = r_rready;
        w_awaddr_nxt     = r_awaddr;
        w_araddr_nxt     = r_araddr;
        w_wdata_nxt      = r_wdata;
        w_rsp_valid_nxt  = r_rsp_valid & ~w_rsp_hs;
        w_rsp_result_nxt = r_rsp_result;
        w_rsp_error_nxt  = r_rsp_error;
        w_op_a_nxt       = r_op_a;
        w_op_b_nxt       = r_op_b;
        w_opcode_nxt     = r_opcode;
        w_err_nxt        = r_err;
        w_aw_done_nxt    = r_aw_done | w_aw_hs;
        w_w_done_nxt     = r_w_done | w_w_hs;
        w_b_done_nxt     = r_b_done | w_b_hs;

        // cmd_ready rises on the first clock after reset release
        if (r_state == S_IDLE) begin
            w_cmd_ready_nxt = ~w_cmd_hs;
        end

        if (w_cmd_hs) begin
            w_op_a_nxt   = cmd_op_a;
            w_op_b_nxt   = cmd_op_b;
            w_opcode_nxt = cmd_opcode;
            w_err_nxt    = 1'b0;
        end else if (w_resp_err) begin
            w_err_nxt = 1'b1;
        end

        // Entry actions load the outputs of the next state so they are registered
        if (w_state_nxt != r_state) begin
            w_bready_nxt  = 1'b0;
            w_rready_nxt  = 1'b0;
            w_aw_done_nxt = 1'b0;
            w_w_done_nxt  = 1'b0;
            w_b_done_nxt  = 1'b0;
            case (w_state_nxt)
                S_WR_A, S_WR_B, S_WR_OP: begin
                    w_awvalid_nxt = 1'b1;
                    w_wvalid_nxt  = 1'b1;
                    w_bready_nxt  = 1'b1;
                    if (w_state_nxt == S_WR_A) begin
                        w_awaddr_nxt = C_BASE_ADDR + C_OFF_A;
                        w_wdata_nxt  = w_src_a;
                    end else if (w_state_nxt == S_WR_B) begin
                        w_awaddr_nxt = C_BASE_ADDR + C_OFF_B;
                        w_wdata_nxt  = w_src_b;
                    end else begin
                        w_awaddr_nxt = C_BASE_ADDR + C_OFF_OP;
                        w_wdata_nxt  = w_src_op;
                    end
                end
                S_RD_RES: begin
                    w_arvalid_nxt = 1'b1;
                    w_rready_nxt  = 1'b1;
                    w_araddr_nxt  = C_BASE_ADDR + C_OFF_RES;
                end
                S_RSP: begin
                    w_rsp_valid_nxt  = 1'b1;
                    w_rsp_result_nxt = M_AXI_RDATA;
                    w_rsp_error_nxt  = r_err | w_resp_err;
                end
                default: begin
                    w_cmd_ready_nxt = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state      <= S_IDLE;
            r_cmd_ready  <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_awaddr     <= '0;
            r_araddr     <= '0;
            r_wdata      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_error  <= 1'b0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_opcode     <= '0;
            r_err        <= 1'b0;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_b_done     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cmd_ready  <= w_cmd_ready_nxt;
            r_awvalid    <= w_awvalid_nxt;
            r_wvalid     <= w_wvalid_nxt;
            r_bready     <= w_bready_nxt;
            r_arvalid    <= w_arvalid_nxt;
            r_rready     <= w_rready_nxt;
            r_awaddr     <= w_awaddr_nxt;
            r_araddr     <= w_araddr_nxt;
            r_wdata      <= w_wdata_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_result <= w_rsp_result_nxt;
            r_rsp_error  <= w_rsp_error_nxt;
            r_op_a       <= w_op_a_nxt;
            r_op_b       <= w_op_b_nxt;
            r_opcode     <= w_opcode_nxt;
            r_err        <= w_err_nxt;
            r_aw_done    <= w_aw_done_nxt;
            r_w_done     <= w_w_done_nxt;
            r_b_done     <= w_b_done_nxt;
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_result    = r_rsp_result;
    assign rsp_error     = r_rsp_error;
    assign M_AXI_AWADDR  = r_awaddr;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_araddr;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule
`default_nettype wire
